// File: rtl/opc6_arb_pkg.sv
// -----------------------------------------------------------------------------
// opc6_arb_pkg
//   Shared types for the opc6 memory arbiter slice.
//
//   Contents:
//     addr_t       - 16-bit RAM / CPU address
//     word_t       - 16-bit data word
//     arb_state_t  - arbiter FSM state (S_ARB, S_CPU_RD, S_DMA_RD)
//     BURST_CNT_W  - width of the DMA burst counter (fairness build only)
// -----------------------------------------------------------------------------
package opc6_arb_pkg;

    typedef logic [15:0] addr_t;
    typedef logic [15:0] word_t;

    // S_ARB    : arbitration / address phase, a RAM access may be issued
    // S_CPU_RD : data phase of a CPU RAM read
    // S_DMA_RD : data phase of a DMA RAM read
    typedef enum logic [1:0] {
        S_ARB    = 2'd0,
        S_CPU_RD = 2'd1,
        S_DMA_RD = 2'd2
    } arb_state_t;

    localparam int unsigned BURST_CNT_W = 4;

endpackage

// File: rtl/opc6_arb_burst_limiter.sv
// -----------------------------------------------------------------------------
// opc6_arb_burst_limiter
//   Counts DMA grants issued while a CPU memory cycle is waiting and raises
//   o_limit_hit once DMA_BURST_MAX such grants have been made, so that the
//   arbiter hands the next arbitration slot to the CPU.
//
//   Parameters:
//     DMA_BURST_MAX  - DMA grants allowed while the CPU waits (1..15)
//   Ports:
//     i_clk          - system clock
//     i_rst_n        - asynchronous active-low reset (clears the counter)
//     i_arb_cycle    - arbiter is in S_ARB this cycle
//     i_cpu_mem      - CPU is presenting a RAM cycle
//     i_cpu_grant    - CPU won arbitration this cycle
//     i_dma_grant    - DMA won arbitration this cycle
//     o_limit_hit    - burst limit reached, CPU must win the next arbitration
// -----------------------------------------------------------------------------
module opc6_arb_burst_limiter
    import opc6_arb_pkg::*;
#(
    parameter int unsigned DMA_BURST_MAX = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_arb_cycle,
    input  logic i_cpu_mem,
    input  logic i_cpu_grant,
    input  logic i_dma_grant,
    output logic o_limit_hit
);

    logic [BURST_CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_cpu_grant || (i_arb_cycle && !i_cpu_mem)) begin
            r_count <= '0;
        end else if (i_dma_grant && i_cpu_mem && !o_limit_hit) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_limit_hit = (r_count == BURST_CNT_W'(DMA_BURST_MAX));

endmodule

// File: rtl/opc6_mem_arbiter.sv
// -----------------------------------------------------------------------------
// opc6_mem_arbiter
//   Shares one synchronous single-port 64Kx16 RAM between the opc6 CPU and a
//   DMA master. CPU bus cycles are paced through cpu_clken: RAM reads take an
//   address phase (clken=0) and a data phase (clken=1); RAM writes, I/O and
//   idle cycles complete in one clock. DMA transfers are slotted into S_ARB
//   cycles; DMA reads return data one clock after dma_gnt, DMA writes ack in
//   the grant cycle.
//
//   Build option:
//     OPC6_ARB_FAIRNESS_EN - when defined, DMA may win at most DMA_BURST_MAX
//                            consecutive arbitrations while the CPU waits.
//                            When undefined, DMA has absolute priority.
//
//   Parameters:
//     DMA_BURST_MAX  - DMA burst limit under fairness (1..15)
//   Ports:
//     clk, reset_b                         - clock, async active-low reset
//     cpu_vpa/vda/vio/rnw                  - CPU cycle qualifiers
//     cpu_address, cpu_dout, cpu_din       - CPU address / write / read data
//     cpu_clken                            - CPU clock enable
//     dma_req/rnw/address/wdata            - DMA request
//     dma_gnt, dma_ack, dma_rdata          - DMA grant / completion / data
//     mem_ce/we/address/wdata, mem_rdata   - RAM port (rdata one clk late)
//     io_ce, io_we, io_rdata               - I/O strobes and read data
// -----------------------------------------------------------------------------
module opc6_mem_arbiter
    import opc6_arb_pkg::*;
#(
    parameter int unsigned DMA_BURST_MAX = 4
) (
    input  logic  clk,
    input  logic  reset_b,

    input  logic  cpu_vpa,
    input  logic  cpu_vda,
    input  logic  cpu_vio,
    input  logic  cpu_rnw,
    input  addr_t cpu_address,
    input  word_t cpu_dout,
    output word_t cpu_din,
    output logic  cpu_clken,

    input  logic  dma_req,
    input  logic  dma_rnw,
    input  addr_t dma_address,
    input  word_t dma_wdata,
    output logic  dma_gnt,
    output logic  dma_ack,
    output word_t dma_rdata,

    output logic  mem_ce,
    output logic  mem_we,
    output addr_t mem_address,
    output word_t mem_wdata,
    input  word_t mem_rdata,

    output logic  io_ce,
    output logic  io_we,
    input  word_t io_rdata
);

    if ((DMA_BURST_MAX == 0) || (DMA_BURST_MAX > 15)) begin : g_bad_burst_max
        $error("opc6_mem_arbiter: DMA_BURST_MAX must be in 1..15");
    end

    arb_state_t r_state;
    arb_state_t w_state_nxt;

    logic w_cpu_mem;
    logic w_cpu_io;
    logic w_in_arb;
    logic w_limit_hit;
    logic w_dma_win;
    logic w_cpu_win;

    assign w_cpu_mem = (cpu_vpa | cpu_vda) & ~cpu_vio;
    assign w_cpu_io  = cpu_vda & cpu_vio;
    assign w_in_arb  = (r_state == S_ARB);

    // DMA wins unless the burst limit is reached while the CPU waits.
    assign w_dma_win = w_in_arb & dma_req & (~w_limit_hit | ~w_cpu_mem);
    assign w_cpu_win = w_in_arb & w_cpu_mem & ~w_dma_win;

`ifdef OPC6_ARB_FAIRNESS_EN
    opc6_arb_burst_limiter #(
        .DMA_BURST_MAX (DMA_BURST_MAX)
    ) u_burst_limiter (
        .i_clk       (clk),
        .i_rst_n     (reset_b),
        .i_arb_cycle (w_in_arb),
        .i_cpu_mem   (w_cpu_mem),
        .i_cpu_grant (w_cpu_win),
        .i_dma_grant (w_dma_win),
        .o_limit_hit (w_limit_hit)
    );
`else
    assign w_limit_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state <= S_ARB;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        // I/O and idle cycles run at full speed in every state; a RAM cycle
        // stalls unless a branch below completes it.
        w_state_nxt = r_state;
        cpu_clken   = ~w_cpu_mem;
        cpu_din     = w_cpu_io ? io_rdata : '0;
        io_ce       = w_cpu_io;
        io_we       = w_cpu_io & ~cpu_rnw;
        mem_ce      = 1'b0;
        mem_we      = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;
        dma_gnt     = 1'b0;
        dma_ack     = 1'b0;
        dma_rdata   = '0;

        case (r_state)
            S_ARB: begin
                if (w_dma_win) begin
                    dma_gnt     = 1'b1;
                    mem_ce      = 1'b1;
                    mem_address = dma_address;
                    if (dma_rnw) begin
                        w_state_nxt = S_DMA_RD;
                    end else begin
                        mem_we    = 1'b1;
                        mem_wdata = dma_wdata;
                        dma_ack   = 1'b1;
                    end
                end else if (w_cpu_win) begin
                    mem_ce      = 1'b1;
                    mem_address = cpu_address;
                    if (cpu_rnw) begin
                        w_state_nxt = S_CPU_RD;
                    end else begin
                        mem_we    = 1'b1;
                        mem_wdata = cpu_dout;
                        cpu_clken = 1'b1;
                    end
                end
            end
            S_CPU_RD: begin
                cpu_din     = mem_rdata;
                cpu_clken   = 1'b1;
                w_state_nxt = S_ARB;
            end
            S_DMA_RD: begin
                dma_ack     = 1'b1;
                dma_rdata   = mem_rdata;
                w_state_nxt = S_ARB;
            end
            default: begin
                w_state_nxt = S_ARB;
            end
        endcase

        // Reset overrides everything: the CPU reset synchroniser needs clken,
        // and nothing may strobe the RAM, I/O or DMA master.
        if (!reset_b) begin
            w_state_nxt = S_ARB;
            cpu_clken   = 1'b1;
            cpu_din     = '0;
            io_ce       = 1'b0;
            io_we       = 1'b0;
            mem_ce      = 1'b0;
            mem_we      = 1'b0;
            mem_address = '0;
            mem_wdata   = '0;
            dma_gnt     = 1'b0;
            dma_ack     = 1'b0;
            dma_rdata   = '0;
        end
    end

endmodule

// File: tb/tb_opc6_mem_arbiter.sv
module tb_opc6_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_b;
    logic        cpu_vpa, cpu_vda, cpu_vio, cpu_rnw;
    logic [15:0] cpu_address, cpu_dout, cpu_din;
    logic        cpu_clken;
    logic        dma_req, dma_rnw;
    logic [15:0] dma_address, dma_wdata, dma_rdata;
    logic        dma_gnt, dma_ack;
    logic        mem_ce, mem_we;
    logic [15:0] mem_address, mem_wdata, mem_rdata;
    logic        io_ce, io_we;
    logic [15:0] io_rdata;

    always #5 clk = ~clk;

    opc6_mem_arbiter #(
        .DMA_BURST_MAX (4)
    ) dut (
        .clk         (clk),
        .reset_b     (reset_b),
        .cpu_vpa     (cpu_vpa),
        .cpu_vda     (cpu_vda),
        .cpu_vio     (cpu_vio),
        .cpu_rnw     (cpu_rnw),
        .cpu_address (cpu_address),
        .cpu_dout    (cpu_dout),
        .cpu_din     (cpu_din),
        .cpu_clken   (cpu_clken),
        .dma_req     (dma_req),
        .dma_rnw     (dma_rnw),
        .dma_address (dma_address),
        .dma_wdata   (dma_wdata),
        .dma_gnt     (dma_gnt),
        .dma_ack     (dma_ack),
        .dma_rdata   (dma_rdata),
        .mem_ce      (mem_ce),
        .mem_we      (mem_we),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .io_ce       (io_ce),
        .io_we       (io_we),
        .io_rdata    (io_rdata)
    );

    // Synchronous 64Kx16 RAM; preload happens while reset is held.
    logic [15:0] ram [0:65535];
    always @(posedge clk) begin
        if (!reset_b) begin
            ram[16'h0000] <= 16'h1234;
            ram[16'h2000] <= 16'h5A5A;
        end else if (mem_ce) begin
            if (mem_we) ram[mem_address] <= mem_wdata;
            else        mem_rdata <= ram[mem_address];
        end
    end

    // Control vector order: {clken, mem_ce, mem_we, dma_gnt, dma_ack, io_ce, io_we}
    localparam logic [6:0] C_IDLE     = 7'b1000000;
    localparam logic [6:0] C_CRD_A    = 7'b0100000;
    localparam logic [6:0] C_CRD_D    = 7'b1000000;
    localparam logic [6:0] C_CWR      = 7'b1110000;
    localparam logic [6:0] C_DGNT_CI  = 7'b1101000;
    localparam logic [6:0] C_DACK_CI  = 7'b1000100;
    localparam logic [6:0] C_DWR_CI   = 7'b1111100;
    localparam logic [6:0] C_DGNT_CW  = 7'b0101000;
    localparam logic [6:0] C_DACK_CW  = 7'b0000100;
    localparam logic [6:0] C_IOW_ACK  = 7'b1000111;
    localparam logic [6:0] C_IOR      = 7'b1000010;

    typedef struct {
        string       name;
        logic [6:0]  ctrl;
        bit          chk_din;
        logic [15:0] din;
        bit          chk_ad;
        logic [15:0] ad;
    } cyc_exp_t;

    typedef struct {
        string       name;
        bit          chk;
        logic [15:0] data;
    } dma_exp_t;

    cyc_exp_t q_cyc[$];
    dma_exp_t q_dma[$];
    int n_checks = 0;
    int n_errors = 0;

    // Monitor: one per-cycle expectation per clock, one DMA response per ack.
    always @(negedge clk) begin
        cyc_exp_t   e;
        dma_exp_t   d;
        logic [6:0] act;
        act = {cpu_clken, mem_ce, mem_we, dma_gnt, dma_ack, io_ce, io_we};
        if (q_cyc.size() > 0) begin
            e = q_cyc.pop_front();
            n_checks++;
            if (act !== e.ctrl) begin
                n_errors++;
                $display("FAIL %s ctrl{clken,ce,we,gnt,ack,ioce,iowe}: got %b expected %b",
                         e.name, act, e.ctrl);
            end
            if (e.chk_din) begin
                n_checks++;
                if (cpu_din !== e.din) begin
                    n_errors++;
                    $display("FAIL %s cpu_din: got %h expected %h", e.name, cpu_din, e.din);
                end
            end
            if (e.chk_ad) begin
                n_checks++;
                if (mem_address !== e.ad) begin
                    n_errors++;
                    $display("FAIL %s mem_address: got %h expected %h", e.name, mem_address, e.ad);
                end
            end
        end
        if (dma_ack === 1'b1) begin
            n_checks++;
            if (q_dma.size() == 0) begin
                n_errors++;
                $display("FAIL dma_ack_unexpected: got ack=1 expected no ack");
            end else begin
                d = q_dma.pop_front();
                if (d.chk && (dma_rdata !== d.data)) begin
                    n_errors++;
                    $display("FAIL %s dma_rdata: got %h expected %h", d.name, dma_rdata, d.data);
                end
            end
        end
    end

    task automatic cyc(input string nm, input logic [6:0] c,
                       input bit cd, input logic [15:0] din,
                       input bit ca, input logic [15:0] ad);
        cyc_exp_t e;
        e.name = nm; e.ctrl = c; e.chk_din = cd; e.din = din; e.chk_ad = ca; e.ad = ad;
        q_cyc.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic exp_dma(input string nm, input bit chk, input logic [15:0] data);
        dma_exp_t d;
        d.name = nm; d.chk = chk; d.data = data;
        q_dma.push_back(d);
    endtask

    task automatic cpu_pins(input logic vpa, input logic vda, input logic vio, input logic rnw,
                            input logic [15:0] a, input logic [15:0] d);
        cpu_vpa = vpa; cpu_vda = vda; cpu_vio = vio; cpu_rnw = rnw;
        cpu_address = a; cpu_dout = d;
    endtask

    task automatic dma_pins(input logic req, input logic rnw,
                            input logic [15:0] a, input logic [15:0] d);
        dma_req = req; dma_rnw = rnw; dma_address = a; dma_wdata = d;
    endtask

    task automatic dma_read_idle(input string nm, input logic [15:0] a, input logic [15:0] d);
        dma_pins(1'b1, 1'b1, a, 16'h0000);
        exp_dma(nm, 1'b1, d);
        cyc({nm, "_gnt"}, C_DGNT_CI, 1'b0, 16'h0, 1'b1, a);
        dma_pins(1'b0, 1'b1, a, 16'h0000);
        cyc({nm, "_ack"}, C_DACK_CI, 1'b0, 16'h0, 1'b0, 16'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected completion before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_b  = 1'b0;
        io_rdata = 16'hC0DE;
        cpu_pins(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
        dma_pins(1'b0, 1'b1, 16'h0000, 16'h0000);
        @(posedge clk);
        #1;

        // Reset held 4 clk, CPU idle
        for (int i = 0; i < 4; i++)
            cyc($sformatf("reset%0d", i), C_IDLE, 1'b1, 16'h0000, 1'b1, 16'h0000);

        // Fetch from 0x0000
        reset_b = 1'b1;
        cpu_pins(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
        cyc("fetch_addr", C_CRD_A, 1'b0, 16'h0, 1'b1, 16'h0000);
        cyc("fetch_data", C_CRD_D, 1'b1, 16'h1234, 1'b0, 16'h0);

        // CPU write 0xBEEF to 0x0100
        cpu_pins(1'b0, 1'b1, 1'b0, 1'b0, 16'h0100, 16'hBEEF);
        cyc("cpu_wr", C_CWR, 1'b0, 16'h0, 1'b1, 16'h0100);
        cpu_pins(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
        cyc("idle", C_IDLE, 1'b0, 16'h0, 1'b0, 16'h0);

        // DMA reads during EAD cycles
        dma_read_idle("dma_rd_0100", 16'h0100, 16'hBEEF);
        dma_read_idle("dma_rd_2000", 16'h2000, 16'h5A5A);

        // DMA write then read-back
        dma_pins(1'b1, 1'b0, 16'h3000, 16'h1111);
        exp_dma("dma_wr_3000", 1'b0, 16'h0);
        cyc("dma_wr_3000", C_DWR_CI, 1'b0, 16'h0, 1'b1, 16'h3000);
        dma_pins(1'b0, 1'b1, 16'h0000, 16'h0000);
        dma_read_idle("dma_rd_3000", 16'h3000, 16'h1111);

        // CPU OUT to 0x00FE during S_DMA_RD, then CPU IN
        dma_pins(1'b1, 1'b1, 16'h0100, 16'h0000);
        exp_dma("dma_rd_io", 1'b1, 16'hBEEF);
        cyc("dma_rd_io_gnt", C_DGNT_CI, 1'b0, 16'h0, 1'b1, 16'h0100);
        dma_pins(1'b0, 1'b1, 16'h0100, 16'h0000);
        cpu_pins(1'b0, 1'b1, 1'b1, 1'b0, 16'h00FE, 16'h00AA);
        cyc("io_out_in_dmard", C_IOW_ACK, 1'b0, 16'h0, 1'b0, 16'h0);
        cpu_pins(1'b0, 1'b1, 1'b1, 1'b1, 16'h00FE, 16'h0000);
        cyc("io_in", C_IOR, 1'b1, 16'hC0DE, 1'b0, 16'h0);

        // DMA held high with a CPU read pending
        cpu_pins(1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000);
        dma_pins(1'b1, 1'b1, 16'h2000, 16'h0000);
`ifdef OPC6_ARB_FAIRNESS_EN
        for (int k = 0; k < 4; k++) begin
            exp_dma($sformatf("fair_dma%0d", k), 1'b1, 16'h5A5A);
            cyc($sformatf("fair_gnt%0d", k), C_DGNT_CW, 1'b0, 16'h0, 1'b1, 16'h2000);
            cyc($sformatf("fair_ack%0d", k), C_DACK_CW, 1'b0, 16'h0, 1'b0, 16'h0);
        end
        cyc("fair_cpu_addr", C_CRD_A, 1'b0, 16'h0, 1'b1, 16'h0000);
        cyc("fair_cpu_data", C_CRD_D, 1'b1, 16'h1234, 1'b0, 16'h0);
        cpu_pins(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
        exp_dma("fair_resume", 1'b1, 16'h5A5A);
        cyc("fair_resume_gnt", C_DGNT_CI, 1'b0, 16'h0, 1'b1, 16'h2000);
        dma_pins(1'b0, 1'b1, 16'h2000, 16'h0000);
        cyc("fair_resume_ack", C_DACK_CI, 1'b0, 16'h0, 1'b0, 16'h0);
`else
        for (int k = 0; k < 20; k++) begin
            exp_dma($sformatf("starve_dma%0d", k), 1'b1, 16'h5A5A);
            cyc($sformatf("starve_gnt%0d", k), C_DGNT_CW, 1'b0, 16'h0, 1'b1, 16'h2000);
            if (k == 19) dma_pins(1'b0, 1'b1, 16'h2000, 16'h0000);
            cyc($sformatf("starve_ack%0d", k), C_DACK_CW, 1'b0, 16'h0, 1'b0, 16'h0);
        end
        cyc("starve_cpu_addr", C_CRD_A, 1'b0, 16'h0, 1'b1, 16'h0000);
        cyc("starve_cpu_data", C_CRD_D, 1'b1, 16'h1234, 1'b0, 16'h0);
        cpu_pins(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
`endif

        // Reset asserted during S_DMA_RD drops the ack and gates I/O strobes
        dma_pins(1'b1, 1'b1, 16'h2000, 16'h0000);
        cyc("pre_rst_gnt", C_DGNT_CI, 1'b0, 16'h0, 1'b1, 16'h2000);
        reset_b = 1'b0;
        dma_pins(1'b0, 1'b1, 16'h0000, 16'h0000);
        cpu_pins(1'b0, 1'b1, 1'b1, 1'b0, 16'h00FE, 16'h0055);
        cyc("rst_in_dmard", C_IDLE, 1'b1, 16'h0000, 1'b1, 16'h0000);
        reset_b = 1'b1;
        cpu_pins(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
        cyc("post_rst_idle", C_IDLE, 1'b0, 16'h0, 1'b0, 16'h0);
        dma_read_idle("dma_reissue", 16'h2000, 16'h5A5A);

        n_checks++;
        if (q_dma.size() != 0) begin
            n_errors++;
            $display("FAIL dma_leftover: got %0d pending acks expected 0", q_dma.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
